// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tank directions, field defaults and position type
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_STAND = 3'd4
  } dir_e;

  localparam int FIELD_W_DEF = 40;
  localparam int FIELD_H_DEF = 30;

  typedef logic [5:0] pos_t;

endpackage

// File: rtl/tank_target_calc.sv
// rtl/tank_target_calc.sv - neighbour cell for a direction, flagging field-edge moves
module tank_target_calc
  import tank_pkg::*;
#(
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int FIELD_H = FIELD_H_DEF
) (
  input  logic [2:0] i_dir,
  input  pos_t       i_x,
  input  pos_t       i_y,
  output pos_t       o_tgt_x,
  output pos_t       o_tgt_y,
  output logic       o_out_of_bounds
);

  // Edge moves keep the current cell as target; the caller only uses the flag.
  always_comb begin
    o_tgt_x         = i_x;
    o_tgt_y         = i_y;
    o_out_of_bounds = 1'b0;
    case (i_dir)
      DIR_UP: begin
        if (i_y == 6'd0) o_out_of_bounds = 1'b1;
        else             o_tgt_y = i_y - 6'd1;
      end
      DIR_DOWN: begin
        if (i_y == 6'(FIELD_H - 1)) o_out_of_bounds = 1'b1;
        else                        o_tgt_y = i_y + 6'd1;
      end
      DIR_LEFT: begin
        if (i_x == 6'd0) o_out_of_bounds = 1'b1;
        else             o_tgt_x = i_x - 6'd1;
      end
      DIR_RIGHT: begin
        if (i_x == 6'(FIELD_W - 1)) o_out_of_bounds = 1'b1;
        else                        o_tgt_x = i_x + 6'd1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tank_move_scheduler.sv
// rtl/tank_move_scheduler.sv - per-frame round-robin move arbitration for all tanks
module tank_move_scheduler
  import tank_pkg::*;
#(
  parameter int N_TANK  = 2,
  parameter int FIELD_W = FIELD_W_DEF,
  parameter int FIELD_H = FIELD_H_DEF,
  parameter int MAP_TMO = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_frame_tick,
  input  logic [3*N_TANK-1:0]   i_dir_req,
  input  logic [6*N_TANK-1:0]   i_tank_x,
  input  logic [6*N_TANK-1:0]   i_tank_y,
  output logic                  o_map_req,
  output logic [5:0]            o_map_x,
  output logic [5:0]            o_map_y,
  input  logic                  i_map_ack,
  input  logic                  i_map_wall,
  output logic [N_TANK-1:0]     o_dir_valid,
  output logic [3*N_TANK-1:0]   o_dir_out,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int IW = (N_TANK > 1) ? $clog2(N_TANK) : 1;
  localparam int TW = $clog2(MAP_TMO + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SNAP  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_MAPQ  = 3'd3;
  localparam logic [2:0] S_ISSUE = 3'd4;

  logic [2:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tmo;
  logic [2:0]    r_verdict;
  logic [2:0]    r_snap_dir [N_TANK];
  pos_t          r_snap_x   [N_TANK];
  pos_t          r_snap_y   [N_TANK];
  logic [2:0]    r_dir_out  [N_TANK];

  logic [2:0] w_cur_dir;
  pos_t       w_tgt_x;
  pos_t       w_tgt_y;
  logic       w_oob;
  logic       w_collide;

  assign w_cur_dir = r_snap_dir[r_idx];

  tank_target_calc #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_target (
    .i_dir           (w_cur_dir),
    .i_x             (r_snap_x[r_idx]),
    .i_y             (r_snap_y[r_idx]),
    .o_tgt_x         (w_tgt_x),
    .o_tgt_y         (w_tgt_y),
    .o_out_of_bounds (w_oob)
  );

  // Only current positions matter; two tanks entering the same free cell is left to Game.
  always_comb begin
    w_collide = 1'b0;
    for (int j = 0; j < N_TANK; j++) begin
      if (j != int'(r_idx) && r_snap_x[j] == w_tgt_x && r_snap_y[j] == w_tgt_y)
        w_collide = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_verdict   <= DIR_STAND;
      o_map_req   <= 1'b0;
      o_map_x     <= '0;
      o_map_y     <= '0;
      o_dir_valid <= '0;
      o_overrun   <= 1'b0;
      for (int k = 0; k < N_TANK; k++) begin
        r_snap_dir[k] <= DIR_STAND;
        r_snap_x[k]   <= '0;
        r_snap_y[k]   <= '0;
        r_dir_out[k]  <= DIR_STAND;
      end
    end else begin
      o_dir_valid <= '0;
      o_overrun   <= i_frame_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_frame_tick) begin
            for (int k = 0; k < N_TANK; k++) begin
              r_snap_dir[k] <= i_dir_req[3*k +: 3];
              r_snap_x[k]   <= i_tank_x[6*k +: 6];
              r_snap_y[k]   <= i_tank_y[6*k +: 6];
            end
            r_idx   <= '0;
            r_state <= S_SNAP;
          end
        end
        S_SNAP: r_state <= S_EVAL;
        S_EVAL: begin
          if (w_cur_dir > DIR_RIGHT || w_oob || w_collide) begin
            r_verdict <= DIR_STAND;
            r_state   <= S_ISSUE;
          end else begin
            o_map_req <= 1'b1;
            o_map_x   <= w_tgt_x;
            o_map_y   <= w_tgt_y;
            r_tmo     <= '0;
            r_state   <= S_MAPQ;
          end
        end
        S_MAPQ: begin
          if (i_map_ack) begin
            r_verdict <= i_map_wall ? DIR_STAND : w_cur_dir;
            o_map_req <= 1'b0;
            r_state   <= S_ISSUE;
          end else if (r_tmo == TW'(MAP_TMO - 1)) begin
            r_verdict <= DIR_STAND;
            o_map_req <= 1'b0;
            r_state   <= S_ISSUE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_ISSUE: begin
          r_dir_out[r_idx]   <= r_verdict;
          o_dir_valid[r_idx] <= 1'b1;
          if (r_idx == IW'(N_TANK - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_EVAL;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != S_IDLE);

  for (genvar g = 0; g < N_TANK; g++) begin : g_pack
    assign o_dir_out[3*g +: 3] = r_dir_out[g];
  end

endmodule

// File: tb/tb_tank_move_scheduler.sv
// tb/tb_tank_move_scheduler.sv - self-checking bench for tank_move_scheduler
`timescale 1ns/1ps
module tb_tank_move_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [5:0] dir_req = 6'o44;
  logic [11:0] tank_x = '0;
  logic [11:0] tank_y = '0;
  logic       map_req;
  logic [5:0] map_x, map_y;
  logic       map_ack = 1'b0;
  logic       map_wall = 1'b0;
  logic [1:0] dir_valid;
  logic [5:0] dir_out;
  logic       busy, overrun;

  tank_move_scheduler #(.N_TANK(2), .FIELD_W(40), .FIELD_H(30), .MAP_TMO(15)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_dir_req(dir_req),
    .i_tank_x(tank_x), .i_tank_y(tank_y), .o_map_req(map_req), .o_map_x(map_x),
    .o_map_y(map_y), .i_map_ack(map_ack), .i_map_wall(map_wall), .o_dir_valid(dir_valid),
    .o_dir_out(dir_out), .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic wall [64][64];
  int  ack_delay = 2;
  bit  withhold = 0;
  bit  stray_ack = 0;
  int  wait_cnt = 0;

  int  pulse_idx [$];
  int  pulse_dir [$];
  int  n_query = 0;
  int  n_overrun = 0;
  int  cur_run = 0;
  int  last_run = 0;
  bit  prev_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Map responder: answers a held request after ack_delay cycles from the wall array.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      map_ack  = 1'b0;
      map_wall = 1'b0;
      if (stray_ack) begin
        map_ack   = 1'b1;
        stray_ack = 0;
      end else if (map_req && !withhold) begin
        if (wait_cnt >= ack_delay) begin
          map_ack  = 1'b1;
          map_wall = wall[map_x][map_y];
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (map_req && !prev_req) n_query++;
    if (map_req) cur_run++;
    else begin
      if (cur_run > 0) last_run = cur_run;
      cur_run = 0;
    end
    prev_req = map_req;
    if (overrun) n_overrun++;
    for (int i = 0; i < 2; i++) begin
      if (dir_valid[i]) begin
        pulse_idx.push_back(i);
        pulse_dir.push_back(int'(dir_out[3*i +: 3]));
      end
    end
  end

  function automatic int model(input int d, input int x, input int y, input int ox,
                               input int oy, output bit q);
    int tx, ty;
    q = 0;
    if (d > 3) return 4;
    tx = x + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
    ty = y + ((d == 1) ? 1 : (d == 0) ? -1 : 0);
    if (tx < 0 || tx >= 40 || ty < 0 || ty >= 30) return 4;
    if (tx == ox && ty == oy) return 4;
    q = 1;
    return wall[tx][ty] ? 4 : d;
  endfunction

  task automatic clear_walls();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) wall[i][j] = 1'b0;
  endtask

  task automatic run_frame(input logic [2:0] d0, input logic [2:0] d1, input int x0,
                           input int y0, input int x1, input int y1, input int extra_tick);
    bit done;
    pulse_idx.delete();
    pulse_dir.delete();
    n_query   = 0;
    n_overrun = 0;
    dir_req = {d1, d0};
    tank_x  = {6'(x1), 6'(x0)};
    tank_y  = {6'(y1), 6'(y0)};
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    // Scramble inputs: the frame must run on the snapshot only.
    dir_req = 6'($urandom);
    tank_x  = 12'($urandom);
    tank_y  = 12'($urandom);
    done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      if (k == extra_tick) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (!busy) done = 1;
    end
    chk("frame_done", 32'(done), 1);
    repeat (3) step();
  endtask

  task automatic check_frame(input int e0, input int e1, input int eq);
    chk("pulse_count", pulse_idx.size(), 2);
    if (pulse_idx.size() == 2) begin
      chk("order0", pulse_idx[0], 0);
      chk("dir0", pulse_dir[0], e0);
      chk("order1", pulse_idx[1], 1);
      chk("dir1", pulse_dir[1], e1);
    end
    chk("map_queries", n_query, eq);
  endtask

  typedef struct {
    logic [2:0] d0, d1;
    int x0, y0, x1, y1;
    int e0, e1, eq;
    bit hold;
    int wx, wy;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{3'd3, 3'd0, 10, 10, 20, 5, 3, 0, 2, 1'b0, 63, 63};
    vecs[1] = '{3'd2, 3'd3, 0, 7, 39, 7, 4, 4, 0, 1'b0, 63, 63};
    vecs[2] = '{3'd1, 3'd4, 5, 5, 5, 6, 4, 4, 0, 1'b0, 63, 63};
    vecs[3] = '{3'd0, 3'd4, 8, 8, 30, 20, 4, 4, 1, 1'b0, 8, 7};
    vecs[4] = '{3'd0, 3'd4, 8, 8, 30, 20, 4, 4, 1, 1'b1, 63, 63};
    vecs[5] = '{3'd6, 3'd7, 3, 3, 4, 4, 4, 4, 0, 1'b0, 63, 63};
    vecs[6] = '{3'd2, 3'd1, 1, 0, 10, 29, 2, 4, 1, 1'b0, 63, 63};
    vecs[7] = '{3'd0, 3'd3, 5, 0, 4, 0, 4, 4, 0, 1'b0, 63, 63};

    clear_walls();
    repeat (3) step();
    chk("rst_dir_valid", 32'(dir_valid), 0);
    chk("rst_dir_out", 32'(dir_out), 36);
    chk("rst_map_req", 32'(map_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    step();

    foreach (vecs[v]) begin
      clear_walls();
      if (vecs[v].wx < 64) wall[vecs[v].wx][vecs[v].wy] = 1'b1;
      withhold  = vecs[v].hold;
      ack_delay = 2;
      run_frame(vecs[v].d0, vecs[v].d1, vecs[v].x0, vecs[v].y0, vecs[v].x1, vecs[v].y1, -1);
      check_frame(vecs[v].e0, vecs[v].e1, vecs[v].eq);
      if (vecs[v].hold) chk("tmo_len", last_run, 15);
    end
    withhold = 0;

    // Second tick two cycles after the first: one overrun, schedule unchanged.
    clear_walls();
    run_frame(3'd3, 3'd0, 10, 10, 20, 5, 1);
    check_frame(3, 0, 2);
    chk("overrun_early", n_overrun, 1);

    // Tick in the final ISSUE cycle is an overrun and starts nothing.
    run_frame(3'd4, 3'd4, 10, 10, 20, 5, 4);
    check_frame(4, 4, 0);
    chk("overrun_last", n_overrun, 1);
    chk("no_restart", 32'(busy), 0);

    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 64; j++) wall[i][j] = ($urandom_range(0, 2) == 0);
    for (int f = 0; f < 40; f++) begin
      int d0, d1, x0, y0, x1, y1, e0, e1;
      bit q0, q1;
      d0 = $urandom_range(0, 7);
      d1 = $urandom_range(0, 7);
      x0 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 39 : 0) : $urandom_range(0, 39);
      y0 = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 29 : 0) : $urandom_range(0, 29);
      x1 = x0 + $urandom_range(0, 2) - 1;
      y1 = y0 + $urandom_range(0, 2) - 1;
      if (x1 < 0) x1 = 0;
      if (x1 > 39) x1 = 39;
      if (y1 < 0) y1 = 0;
      if (y1 > 29) y1 = 29;
      e0 = model(d0, x0, y0, x1, y1, q0);
      e1 = model(d1, x1, y1, x0, y0, q1);
      ack_delay = $urandom_range(0, 4);
      run_frame(3'(d0), 3'(d1), x0, y0, x1, y1, -1);
      check_frame(e0, e1, int'(q0) + int'(q1));
    end

    // Reset while a map query is outstanding, then a stray ack.
    clear_walls();
    withhold = 1;
    dir_req = {3'd4, 3'd3};
    tank_x  = {6'd20, 6'd10};
    tank_y  = {6'd5, 6'd10};
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        step();
        if (map_req) seen = 1;
      end
      chk("mapq_reached", 32'(seen), 1);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("rst_mid_map_req", 32'(map_req), 0);
    chk("rst_mid_dir_out", 32'(dir_out), 36);
    chk("rst_mid_busy", 32'(busy), 0);
    rst = 1'b0;
    pulse_idx.delete();
    stray_ack = 1;
    repeat (6) step();
    chk("stray_pulses", pulse_idx.size(), 0);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_map_req", 32'(map_req), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
